// File: rtl/cvita_pkt_rr_arb_pkg.sv
// Shared constants and types for the packet round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cvita_arb_pkg;

    // Settings-bus register offsets, relative to the arbiter's SR_BASE
    localparam logic [7:0] SR_MASK_OFFS    = 8'd0;
    localparam logic [7:0] SR_CNT_CLR_OFFS = 8'd1;

    // IDLE: choosing the next requester; PASS: forwarding one whole packet
    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cvita_pkt_rr_arb_if.sv
// Bundle of N requester streams and one arbitrated output stream.
// Latency: n/a (wiring only).
// Backpressure: ready flows from the output side back to the granted input.
interface cvita_pkt_rr_arb_if #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 64
) ();

    logic [NUM_INPUTS*WIDTH-1:0] i_tdata;
    logic [NUM_INPUTS-1:0]       i_tlast;
    logic [NUM_INPUTS-1:0]       i_tvalid;
    logic [NUM_INPUTS-1:0]       i_tready;
    logic [WIDTH-1:0]            o_tdata;
    logic                        o_tlast;
    logic                        o_tvalid;
    logic                        o_tready;

    // Environment side: sources the requester streams, sinks the output
    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );

    // Arbiter side: consumes the requester streams, drives the output
    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );

endinterface

// File: rtl/cvita_pkt_rr_arb_rr_pick.sv
// Rotating-priority encoder: first set request after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and last_grant.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic                 vld,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_W = (IW + 1)'(N);

    logic [IW:0]  base;
    logic [N-1:0] rot;
    logic [IW:0]  off;
    logic [IW:0]  sum;

    // Rotate the request vector so bit 0 is the input right after last_grant,
    // take the lowest set bit, then map the offset back to an input index.
    always_comb begin
        base = {1'b0, last_grant} + (IW + 1)'(1);
        rot  = N'({req, req} >> base);
        off  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = (IW + 1)'(j);
            end
        end
        sum = base + off;
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        vld = |req;
        idx = IW'(sum);
    end

endmodule

// File: rtl/cvita_pkt_rr_arb.sv
// Packet-granular round-robin arbiter onto one CVITA AXI4-Stream output.
// Latency: one IDLE decision cycle per packet, then zero-cycle pass-through.
// Backpressure: o_tready routed to the granted input only; others held off.
module cvita_pkt_rr_arb
    import cvita_arb_pkg::*;
#(
    parameter int         NUM_INPUTS = 4,
    parameter int         WIDTH      = 64,
    parameter logic [7:0] SR_BASE    = 8'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          set_stb,
    input  logic [7:0]                    set_addr,
    input  logic [31:0]                   set_data,
    output logic [31:0]                   rb_data,
    cvita_pkt_rr_arb_if.slave             strm,
    output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
    output logic                          busy
);

    localparam int              GW           = $clog2(NUM_INPUTS);
    localparam logic [7:0]      MASK_ADDR    = SR_BASE + SR_MASK_OFFS;
    localparam logic [7:0]      CNT_CLR_ADDR = SR_BASE + SR_CNT_CLR_OFFS;
    localparam logic [GW-1:0]   LAST_INIT    = GW'(NUM_INPUTS - 1);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [GW-1:0]          last_grant;
    logic [NUM_INPUTS-1:0]  mask;
    logic [31:0]            pkt_cnt;
    logic [NUM_INPUTS-1:0]  req;
    logic                   pick_vld;
    logic [GW-1:0]          pick_idx;
    logic                   pkt_done;
    logic [WIDTH-1:0]       in_dat [NUM_INPUTS];

    assign req      = strm.i_tvalid & mask;
    assign pkt_done = (state == PASS) && strm.o_tvalid && strm.o_tready && strm.o_tlast;
    assign busy     = (state == PASS);
    assign rb_data  = pkt_cnt;

    rr_pick #(
        .N (NUM_INPUTS)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .vld        (pick_vld),
        .idx        (pick_idx)
    );

    // Split the flattened input data bus into per-port words
    always_comb begin
        for (int n = 0; n < NUM_INPUTS; n++) begin
            in_dat[n] = strm.i_tdata[n*WIDTH +: WIDTH];
        end
    end

    // Next state: grant on any enabled request, release on the last beat;
    // a soft clear abandons whatever is in flight
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = PASS;
            PASS:    if (pkt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping: capture the winner in IDLE, remember it once its
    // packet has fully left so the search resumes just after it
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_idx  <= '0;
            last_grant <= LAST_INIT;
        end else if (clear) begin
            last_grant <= LAST_INIT;
        end else begin
            if (state == IDLE && pick_vld) begin
                grant_idx <= pick_idx;
            end
            if (pkt_done) begin
                last_grant <= grant_idx;
            end
        end
    end

    // Settings registers and forwarded-packet counter; a counter-clear write
    // overrides an increment landing in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            mask    <= '1;
            pkt_cnt <= '0;
        end else begin
            if (set_stb && set_addr == MASK_ADDR) begin
                mask <= NUM_INPUTS'(set_data);
            end
            if (set_stb && set_addr == CNT_CLR_ADDR) begin
                pkt_cnt <= '0;
            end else if (pkt_done && !clear) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    // Pass-through mux: only the granted input sees ready, nothing leaves
    // the arbiter outside PASS
    always_comb begin
        strm.o_tdata  = '0;
        strm.o_tlast  = 1'b0;
        strm.o_tvalid = 1'b0;
        strm.i_tready = '0;
        if (state == PASS) begin
            strm.o_tdata             = in_dat[grant_idx];
            strm.o_tlast             = strm.i_tlast[grant_idx];
            strm.o_tvalid            = strm.i_tvalid[grant_idx];
            strm.i_tready[grant_idx] = strm.o_tready;
        end
    end

endmodule
